// File: rtl/piso_ctrl_pkg.sv
// Shared types and constants for the PISO transmit arbiter.
// Build option: PISO_PARITY_EN adds an even-parity bit after each frame.
package piso_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_GAP   = 1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_GAP    = 2'd2,
    ST_PARITY = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift register, MSB first, cleared on reset.
module piso_shifter
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q;

  // Load has priority over shift; zeros fill from the LSB end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= din;
    end else if (shift) begin
      shreg_q <= shreg_q << 1;
    end else begin
      shreg_q <= shreg_q;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin serial transmitter with idle gap between frames.
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_tx_arbiter
  import piso_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdo,
  output logic             frame,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned BW       = $clog2(WIDTH + 1);
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  state_e            state_q, state_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [GW-1:0]     gapcnt_q, gapcnt_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              pick_s;
  logic              hs_s;
  logic              msb_s;
  logic [WIDTH-1:0]  word_s;
  state_e            post_frame_s;

`ifdef PISO_PARITY_EN
  logic parity_q;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // Parity of the granted word is captured alongside the shifter load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (hs_s) begin
      parity_q <= even_parity(word_s);
    end else begin
      parity_q <= parity_q;
    end
  end
`endif

  // Round-robin pick: on a tie, favour whoever was not served last.
  always_comb begin
    pick_s = REQ0;
    if (req0_valid && req1_valid) begin
      pick_s = ~last_q;
    end else if (req1_valid) begin
      pick_s = REQ1;
    end else begin
      pick_s = REQ0;
    end
  end

  assign req0_ready   = reset && (state_q == ST_IDLE) && (pick_s == REQ0) && req0_valid;
  assign req1_ready   = reset && (state_q == ST_IDLE) && (pick_s == REQ1) && req1_valid;
  assign hs_s         = req0_ready || req1_ready;
  assign word_s       = (pick_s == REQ1) ? req1_data : req0_data;
  assign post_frame_s = (GAP > 0) ? ST_GAP : ST_IDLE;

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (hs_s),
    .shift (state_q == ST_SHIFT),
    .din   (word_s),
    .msb   (msb_s)
  );

  // Next-state logic for the transmit sequence.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
          grant_d  = pick_s;
          last_d   = pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bitcnt_q == BW'(WIDTH - 1)) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = post_frame_s;
`endif
          gapcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + BW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        state_d  = post_frame_s;
        gapcnt_d = '0;
      end
`endif
      ST_GAP: begin
        if (gapcnt_q == GW'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      grant_q  <= REQ0;
      last_q   <= REQ1;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  // Serial outputs; sdo is forced low outside a frame.
  always_comb begin
    frame = 1'b0;
    sdo   = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        frame = 1'b1;
        sdo   = msb_s;
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        frame = 1'b1;
        sdo   = parity_q;
      end
`endif
      default: begin
        frame = 1'b0;
        sdo   = 1'b0;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter with WIDTH=4, GAP=1.
// Honours PISO_PARITY_EN when the design is built with it.
module tb_piso_tx_arbiter;

`ifdef PISO_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       sdo, frame, busy, grant_id;

  int n_cmp;
  int n_bad;
  int waited;

  piso_tx_arbiter #(.WIDTH(4), .GAP(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sdo        (sdo),
    .frame      (frame),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for requester id to be accepted; returns just after the handshake edge.
  task automatic wait_ready(input logic id, input logic drop, output int cycles);
    logic got;
    got    = 1'b0;
    cycles = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else cycles++;
    end
    check_eq("ready_seen", {31'd0, got}, 32'd1);
    check_eq("other_ready", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    check_eq("idle_frame", {31'd0, frame}, 32'd0);
    @(posedge clk);
    #1;
    if (drop) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end else begin
      req0_valid = req0_valid;
    end
  endtask

  // Checks the serial frame and the following gap; ends in the next IDLE cycle.
  task automatic expect_frame(input logic id, input logic [3:0] data);
    logic exp_bit;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      exp_bit = (i < 4) ? data[3 - i] : ^data;
      check_eq("frame_hi", {31'd0, frame}, 32'd1);
      check_eq("sdo_bit", {31'd0, sdo}, {31'd0, exp_bit});
      check_eq("busy_hi", {31'd0, busy}, 32'd1);
      check_eq("grant_id", {31'd0, grant_id}, {31'd0, id});
      check_eq("ready_blk", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(negedge clk);
    check_eq("gap_frame", {31'd0, frame}, 32'd0);
    check_eq("gap_sdo", {31'd0, sdo}, 32'd0);
    check_eq("gap_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = 4'h0; req1_data  = 4'h0;
    #2;
    reset = 1'b0;
    #2;
    check_eq("rst_sdo", {31'd0, sdo}, 32'd0);
    check_eq("rst_frame", {31'd0, frame}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_grant", {31'd0, grant_id}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single request from requester 0
    req0_valid = 1'b1; req0_data = 4'b1101;
    wait_ready(1'b0, 1'b1, waited);
    check_eq("t1_latency", waited, 32'd0);
    expect_frame(1'b0, 4'b1101);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    req0_valid = 1'b1; req0_data = 4'hA;
    req1_valid = 1'b1; req1_data = 4'h5;
    wait_ready(1'b0, 1'b1, waited);
    expect_frame(1'b0, 4'hA);
    wait_ready(1'b1, 1'b1, waited);
    check_eq("t2_second_wait", waited, 32'd0);
    expect_frame(1'b1, 4'h5);

    // Requester 1 held valid with fresh data each acceptance
    req1_valid = 1'b1; req1_data = 4'h3;
    wait_ready(1'b1, 1'b0, waited);
    req1_data = 4'hC;
    expect_frame(1'b1, 4'h3);
    wait_ready(1'b1, 1'b1, waited);
    check_eq("t3_back2back", waited, 32'd0);
    expect_frame(1'b1, 4'hC);

    // Reset during the third shift cycle aborts the frame
    req0_valid = 1'b1; req0_data = 4'b1101;
    wait_ready(1'b0, 1'b1, waited);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("t4_mid_frame", {31'd0, frame}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t4_abort_sdo", {31'd0, sdo}, 32'd0);
    check_eq("t4_abort_frame", {31'd0, frame}, 32'd0);
    check_eq("t4_abort_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_abort_grant", {31'd0, grant_id}, 32'd0);
    req0_valid = 1'b1; req0_data = 4'b0110;
    #1;
    check_eq("t4_ready_forced", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_ready(1'b0, 1'b1, waited);
    expect_frame(1'b0, 4'b0110);

    // Tie after requester 0 was served: requester 1 wins, then requester 0
    req0_valid = 1'b1; req0_data = 4'h9;
    req1_valid = 1'b1; req1_data = 4'h2;
    wait_ready(1'b1, 1'b1, waited);
    expect_frame(1'b1, 4'h2);
    wait_ready(1'b0, 1'b1, waited);
    expect_frame(1'b0, 4'h9);

    // Sweep all word values through requester 0
    for (int w = 0; w < 16; w++) begin
      req0_valid = 1'b1; req0_data = 4'(w);
      wait_ready(1'b0, 1'b1, waited);
      check_eq("t6_period", waited, 32'd0);
      expect_frame(1'b0, 4'(w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
